// File: rtl/matmul_stream_host_pkg.sv
// matmul_pkg: dimensions, matrix type and host FSM states shared with the matmul array.
package matmul_pkg;
  localparam int N = 4;
  localparam int W = 8;
  typedef logic [0:N-1][0:N-1][W-1:0] mat_t;
  typedef enum logic [1:0] {LOAD_A, LOAD_B, RUN, DRAIN} state_t;
endpackage

// File: rtl/matmul_stream_host_if.sv
// matmul_stream_host_if: element input stream and result output stream.
interface matmul_stream_host_if #(parameter int W = matmul_pkg::W);
  logic in_valid, in_ready, out_valid, out_ready, out_last;
  logic [W-1:0] in_data, out_data;
  modport slave(input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_last);
  modport master(output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/matmul_stream_host_counter.sv
// mat_elem_counter: row-major element index shared by loads and drain, wrapping after the last element.
module mat_elem_counter #(
  parameter int NN = 16,
  localparam int IW = $clog2(NN)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          inc,
  output logic [IW-1:0] idx,
  output logic          last
);
  assign last = idx == IW'(NN - 1);
  always_ff @(posedge clock)
    if (reset) idx <= '0;
    else if (inc) idx <= last ? '0 : idx + 1'b1;
endmodule

// File: rtl/matmul_stream_host.sv
// matmul_stream_host: streams A and B into a matmul array, runs it with a timeout, streams the result out.
module matmul_stream_host
  import matmul_pkg::*;
#(
  parameter int N = matmul_pkg::N,
  parameter int W = matmul_pkg::W,
  parameter int TIMEOUT = 64
) (
  input  logic                             clock,
  input  logic                             reset,
  matmul_stream_host_if.slave              s,
  output logic                             mm_reset,
  output logic [0:N-1][0:N-1][W-1:0]       mm_a,
  output logic [0:N-1][0:N-1][W-1:0]       mm_b,
  input  logic [0:N-1][0:N-1][W-1:0]       mm_c,
  input  logic                             mm_complete,
  output logic                             busy,
  output logic                             timeout_err
);
  localparam int NN = N * N;
  localparam int IW = $clog2(NN);
  localparam int RW = $clog2(N);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state;
  logic [IW-1:0] idx, nidx;
  logic [RW-1:0] row, col, nrow, ncol;
  logic [CW-1:0] run_cnt;
  logic [0:N-1][0:N-1][W-1:0] result;
  logic last, in_xfer, out_xfer, completed, done;
  assign in_xfer = s.in_valid && s.in_ready;
  assign out_xfer = s.out_valid && s.out_ready;
  assign nidx = idx + 1'b1;
  assign row = RW'(idx / IW'(N));
  assign col = RW'(idx % IW'(N));
  assign nrow = RW'(nidx / IW'(N));
  assign ncol = RW'(nidx % IW'(N));
  // the array's complete flag is stale during the first RUN cycle, so it is only trusted afterwards
  assign completed = run_cnt != '0 && mm_complete;
  assign done = completed || run_cnt == CW'(TIMEOUT - 1);
  mat_elem_counter #(.NN(NN)) u_cnt (
    .clock(clock),
    .reset(reset),
    .inc(in_xfer || out_xfer),
    .idx(idx),
    .last(last)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= LOAD_A;
      run_cnt <= '0;
      s.in_ready <= 1'b1;
      s.out_valid <= 1'b0;
      s.out_last <= 1'b0;
      s.out_data <= '0;
      mm_reset <= 1'b1;
      busy <= 1'b0;
      timeout_err <= 1'b0;
      mm_a <= '0;
      mm_b <= '0;
      result <= '0;
    end else begin
      case (state)
        LOAD_A: if (in_xfer) begin
          mm_a[row][col] <= s.in_data;
          if (last) state <= LOAD_B;
        end
        LOAD_B: if (in_xfer) begin
          mm_b[row][col] <= s.in_data;
          if (last) begin
            state <= RUN;
            s.in_ready <= 1'b0;
            mm_reset <= 1'b0;
            busy <= 1'b1;
            run_cnt <= '0;
          end
        end
        RUN: begin
          run_cnt <= run_cnt + 1'b1;
          if (done) begin
            state <= DRAIN;
            result <= mm_c;
            mm_reset <= 1'b1;
            busy <= 1'b0;
            s.out_valid <= 1'b1;
            s.out_data <= mm_c[0][0];
            s.out_last <= 1'b0;
            if (!completed) timeout_err <= 1'b1;
          end
        end
        DRAIN: if (out_xfer) begin
          if (last) begin
            state <= LOAD_A;
            s.out_valid <= 1'b0;
            s.out_last <= 1'b0;
            s.in_ready <= 1'b1;
          end else begin
            s.out_data <= result[nrow][ncol];
            s.out_last <= nidx == IW'(NN - 1);
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_matmul_stream_host.sv
// tb_matmul_stream_host: table of full load/run/drain operations against a product model, plus reset sequences.
module tb_matmul_stream_host;
  import matmul_pkg::*;
  logic clock = 1'b0;
  logic reset;
  logic mm_reset, mm_complete, busy, timeout_err;
  mat_t mm_a, mm_b, mm_c;
  matmul_stream_host_if ifc();
  matmul_stream_host #(.N(N), .W(W), .TIMEOUT(64)) dut (
    .clock(clock),
    .reset(reset),
    .s(ifc),
    .mm_reset(mm_reset),
    .mm_a(mm_a),
    .mm_b(mm_b),
    .mm_c(mm_c),
    .mm_complete(mm_complete),
    .busy(busy),
    .timeout_err(timeout_err)
  );
  always #5 clock = ~clock;
  int total = 0, bad = 0;
  int stub_mode = 0, ready_at = 10, scnt = 0;
  mat_t ea, eb, ec;
  // stub array: counts cycles since release, product valid only from ready_at, garbage before that
  always @(posedge clock) scnt <= mm_reset ? 0 : scnt + 1;
  always_comb begin : stub
    int acc;
    mm_complete = 1'b0;
    if (stub_mode == 0) mm_complete = !mm_reset && scnt == 10;
    else if (stub_mode == 2) mm_complete = mm_reset || scnt == 0 || scnt == 10;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        acc = 0;
        for (int k = 0; k < N; k++) acc += int'(mm_a[i][k]) * int'(mm_b[k][j]);
        mm_c[i][j] = (!mm_reset && scnt >= ready_at) ? W'(acc) : 8'hA5;
      end
  end
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic send(input logic [W-1:0] d);
    int b = 0;
    ifc.in_valid = 1'b1;
    ifc.in_data = d;
    while (!ifc.in_ready && b < 50) begin
      @(negedge clock);
      b++;
    end
    if (b >= 50) chk("in_ready_wait", 0, 1);
    @(negedge clock);
    ifc.in_valid = 1'b0;
  endtask
  typedef struct {
    int pat;
    int mode;
    bit gap;
    int stall;
    int exp_run;
    bit exp_terr;
  } vec_t;
  vec_t tbl[6];
  task automatic run_op(input vec_t v);
    int rc, k, st, cyc, acc;
    bit r;
    stub_mode = v.mode;
    ready_at = v.mode == 1 ? 63 : 10;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ea[i][j] = v.pat == 1 ? W'(i + j) : W'($urandom);
        eb[i][j] = v.pat == 1 ? W'(i + i * j + j) : W'($urandom);
      end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        acc = 0;
        for (int m = 0; m < N; m++) acc += int'(ea[i][m]) * int'(eb[m][j]);
        ec[i][j] = W'(acc);
      end
    for (int e = 0; e < 2 * N * N; e++) begin
      if (v.gap && e % 2 == 1) begin
        ifc.in_valid = 1'b0;
        @(negedge clock);
      end
      send(e < N * N ? ea[e / N][e % N] : eb[(e - N * N) / N][(e - N * N) % N]);
    end
    chk("run_entry_busy", busy, 1);
    chk("run_entry_mm_reset", mm_reset, 0);
    chk("run_entry_in_ready", ifc.in_ready, 0);
    chk("mm_a", mm_a, ea);
    chk("mm_b", mm_b, eb);
    rc = 0;
    while (busy && rc < 200) begin
      rc++;
      @(negedge clock);
    end
    chk("run_cycles", rc, v.exp_run);
    chk("drain_valid", ifc.out_valid, 1);
    chk("drain_mm_reset", mm_reset, 1);
    chk("timeout_err", timeout_err, v.exp_terr);
    k = 0;
    st = 0;
    cyc = 0;
    while (k < N * N && cyc < 400) begin
      if (v.stall == 7 && k == 7 && st < 5) begin
        r = 1'b0;
        st++;
      end else r = v.stall == -2 ? $urandom_range(0, 3) != 0 : 1'b1;
      ifc.out_ready = r;
      chk("out_valid", ifc.out_valid, 1);
      chk($sformatf("out_data[%0d]", k), ifc.out_data, ec[k / N][k % N]);
      chk("out_last", ifc.out_last, k == N * N - 1);
      if (r) k++;
      @(negedge clock);
      cyc++;
    end
    if (cyc >= 400) chk("drain_budget", 0, 1);
    ifc.out_ready = 1'b0;
    chk("end_out_valid", ifc.out_valid, 0);
    chk("end_in_ready", ifc.in_ready, 1);
    chk("end_busy", busy, 0);
  endtask
  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"}, ifc.in_ready, 1);
    chk({tag, "_out_valid"}, ifc.out_valid, 0);
    chk({tag, "_out_last"}, ifc.out_last, 0);
    chk({tag, "_out_data"}, ifc.out_data, 0);
    chk({tag, "_mm_reset"}, mm_reset, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
    chk({tag, "_mm_a"}, mm_a, 0);
    chk({tag, "_mm_b"}, mm_b, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{1, 0, 1'b0, -1, 11, 1'b0};
    tbl[1] = '{0, 0, 1'b1, -1, 11, 1'b0};
    tbl[2] = '{0, 0, 1'b0, 7, 11, 1'b0};
    tbl[3] = '{0, 2, 1'b1, -2, 11, 1'b0};
    tbl[4] = '{0, 1, 1'b0, -1, 64, 1'b1};
    tbl[5] = '{0, 0, 1'b0, -2, 11, 1'b1};
    reset = 1'b1;
    ifc.in_valid = 1'b0;
    ifc.in_data = '0;
    ifc.out_ready = 1'b0;
    repeat (2) @(negedge clock);
    chk_reset_state("reset");
    reset = 1'b0;
    for (int t = 0; t < 6; t++) run_op(tbl[t]);
    for (int e = 0; e < N * N + 9; e++) send(W'($urandom));
    reset = 1'b1;
    ifc.in_valid = 1'b1;
    ifc.in_data = 8'h5A;
    @(negedge clock);
    reset = 1'b0;
    ifc.in_valid = 1'b0;
    chk_reset_state("midload");
    run_op('{1, 0, 1'b0, -1, 11, 1'b0});
    run_op('{0, 2, 1'b0, -2, 11, 1'b0});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
